// File: rtl/mips_mem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// - arb_state_t : arbiter FSM states (IDLE, ACCESS, DONE_R).
// - master_id_t : one-bit master identifier.
// - MASTER_CPU / MASTER_LDR : ids of the CPU data port and the test/debug loader.
// - other_master(): returns the id of the opposite master.
package mips_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE_R = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_LDR = 1'b1;

  function automatic master_id_t other_master(input master_id_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/mips_data_mem_arbiter_if.sv
// Avalon-style memory bus used for both arbiter masters and the memory side.
// Handshake: a master requests by raising read or write (write wins if both
// are high) and must hold address, writedata and strobes stable while
// waitrequest is high; the transfer completes on the rising clock edge that
// ends a cycle in which the request is high and waitrequest is low. Read data
// is valid in that completing cycle.
// Signals:
//   address[ADDR_W], write, read, writedata[DATA_W] : master -> slave
//   readdata[DATA_W], waitrequest                   : slave -> master
// Modports: master (drives request), slave (answers request).
interface mips_data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (output address, write, read, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  address, write, read, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/mips_mem_arb_grant.sv
// Combinational winner selection between the two arbiter masters.
// Ports:
//   req0, req1 : request from CPU (master 0) and loader (master 1)
//   last_grant : master granted most recently
//   grant      : winning master (meaningful only when a request is present)
// Build option: MEM_ARB_RR_EN selects round-robin on contention (the master
// other than last_grant wins); without it master 0 always has priority.
module mips_mem_arb_grant
  import mips_mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_t last_grant,
  output master_id_t grant
);

  always_comb begin
    grant = MASTER_CPU;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      grant = other_master(last_grant);
    end else if (req1) begin
      grant = MASTER_LDR;
    end
`else
    if (!req0 && req1) begin
      grant = MASTER_LDR;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority ignores history; last_grant is still tracked upstream.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// Two-master arbiter sharing a single synchronous data memory (1-cycle read)
// between the CPU data port (m0) and the test/debug loader (m1).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clk_enable      : global enable; when low all state holds, strobes are 0
//   m0, m1          : slave side of each master's bus (waitrequest stalls)
//   mem             : master side toward the data memory
//   dbg_state, dbg_owner, dbg_last_grant : FSM observation
// Build option: MEM_ARB_RR_EN (round-robin grant, see mips_mem_arb_grant).
// Accesses are serialised: a write occupies IDLE->ACCESS, a read
// IDLE->ACCESS->DONE_R. Read data is bypassed from mem.readdata in DONE_R and
// held in a per-master register afterwards.
module mips_data_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  mips_data_mem_arbiter_if.slave  m0,
  mips_data_mem_arbiter_if.slave  m1,
  mips_data_mem_arbiter_if.master mem,
  output arb_state_t dbg_state,
  output master_id_t dbg_owner,
  output master_id_t dbg_last_grant
);

  arb_state_t        state_q, state_d;
  master_id_t        owner_q, owner_d;
  master_id_t        last_grant_q, last_grant_d;
  master_id_t        grant;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              req0, req1;
  logic              own_wr, own_rd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              wr_done, rd_done;

  logic              mem_write_c, mem_read_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Current owner's request, selected by the registered owner id.
  assign own_wr    = (owner_q == MASTER_LDR) ? m1.write     : m0.write;
  assign own_rd    = (owner_q == MASTER_LDR) ? m1.read      : m0.read;
  assign own_addr  = (owner_q == MASTER_LDR) ? m1.address   : m0.address;
  assign own_wdata = (owner_q == MASTER_LDR) ? m1.writedata : m0.writedata;

  // Completion cycles: a write completes in ACCESS, a read in DONE_R.
  // Nothing completes while the clock enable is low.
  assign wr_done = (state_q == ACCESS) && own_wr && clk_enable;
  assign rd_done = (state_q == DONE_R) && clk_enable;

  mips_mem_arb_grant u_grant (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_c  = own_addr;
        mem_wdata_c = own_wdata;
        if (own_wr) begin
          mem_write_c = 1'b1;
          state_d     = IDLE;
        end else if (own_rd) begin
          mem_read_c = 1'b1;
          state_d    = DONE_R;
        end else begin
          // Owner dropped its request: abort without touching memory.
          state_d = IDLE;
        end
      end
      DONE_R: begin
        if (owner_q == MASTER_LDR) begin
          rdata1_d = mem.readdata;
        end else begin
          rdata0_d = mem.readdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= MASTER_CPU;
      last_grant_q <= MASTER_LDR;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Strobes are suppressed while frozen or in reset so a dropped transaction
  // never reaches memory.
  assign mem.write     = mem_write_c & clk_enable & ~reset;
  assign mem.read      = mem_read_c & clk_enable & ~reset;
  assign mem.address   = reset ? '0 : mem_addr_c;
  assign mem.writedata = reset ? '0 : mem_wdata_c;

  assign m0.waitrequest = req0 & ~((wr_done | rd_done) & (owner_q == MASTER_CPU));
  assign m1.waitrequest = req1 & ~((wr_done | rd_done) & (owner_q == MASTER_LDR));

  assign m0.readdata = (rd_done && owner_q == MASTER_CPU) ? mem.readdata : rdata0_q;
  assign m1.readdata = (rd_done && owner_q == MASTER_LDR) ? mem.readdata : rdata1_q;

  assign dbg_state      = state_q;
  assign dbg_owner      = owner_q;
  assign dbg_last_grant = last_grant_q;

  // The data memory never stalls.
  logic unused_mem_wait;
  assign unused_mem_wait = mem.waitrequest;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Testbench for mips_data_mem_arbiter: directed scenarios followed by two
// randomized masters, checked against a word-level memory reference model.
`timescale 1ns/1ps
module tb_mips_data_mem_arbiter;
  import mips_mem_arb_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  arb_state_t dbg_state;
  master_id_t dbg_owner;
  master_id_t dbg_last_grant;

  mips_data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  mips_data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  mips_data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mips_data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem            (mem_bus),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory model (1-cycle synchronous read) ----------------
  logic [DATA_W-1:0] mem_arr [MEM_WORDS];
  assign mem_bus.waitrequest = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] <= '0;
      mem_bus.readdata <= '0;
    end else if (clk_enable) begin
      if (mem_bus.write) mem_arr[mem_bus.address[5:2]] <= mem_bus.writedata;
      if (mem_bus.read)  mem_bus.readdata <= mem_arr[mem_bus.address[5:2]];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [DATA_W-1:0] last_rd [2];
  logic              rand_active = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      m0_bus.write = wr; m0_bus.read = rd; m0_bus.address = addr; m0_bus.writedata = wd;
    end else begin
      m1_bus.write = wr; m1_bus.read = rd; m1_bus.address = addr; m1_bus.writedata = wd;
    end
  endtask

  function automatic logic get_wait(input int id);
    return (id == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
  endfunction

  function automatic logic [31:0] get_rdata(input int id);
    return (id == 0) ? m0_bus.readdata : m1_bus.readdata;
  endfunction

  // One complete transfer. lat = cycles from request cycle to completion
  // cycle (-1 on timeout). Data is checked against the reference model:
  // reads see every previously completed write; writes leave readdata alone.
  task automatic xfer(input int id, input logic wr, input logic rd,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdata);
    logic [3:0] idx;
    idx = addr[5:2];
    lat = -1;
    @(posedge clk); #1;
    drive_req(id, wr, rd, addr, wd);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!get_wait(id)) begin
        lat = c;
        break;
      end
    end
    rdata = get_rdata(id);
    check_eq($sformatf("m%0d_completed", id), 32'(lat >= 0), 32'd1);
    if (lat >= 0) begin
      if (wr) begin
        check_eq($sformatf("m%0d_wr_strobe", id), 32'(mem_bus.write), 32'd1);
        check_eq($sformatf("m%0d_wr_addr", id), mem_bus.address, addr);
        check_eq($sformatf("m%0d_wr_data", id), mem_bus.writedata, wd);
        check_eq($sformatf("m%0d_rdata_kept", id), rdata, last_rd[id]);
        ref_mem[idx] = wd;
      end else begin
        check_eq($sformatf("m%0d_rd_data", id), rdata, ref_mem[idx]);
        last_rd[id] = ref_mem[idx];
      end
    end
    @(posedge clk); #1;
    drive_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rand_master(input int id, input int n);
    int          gap;
    int          op;
    int          lat;
    logic [31:0] rdata;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      op = $urandom_range(0, 2);  // 0 read, 1 write, 2 read+write
      xfer(id, op != 0, op != 1, 32'($urandom_range(0, MEM_WORDS - 1)) * 4, $urandom, lat, rdata);
    end
  endtask

  // Idle masters never stall; memory strobes are mutually exclusive.
  always @(negedge clk) begin
    if (rand_active) begin
      if (!(m0_bus.read || m0_bus.write)) check_eq("m0_idle_wait", 32'(m0_bus.waitrequest), 32'd0);
      if (!(m1_bus.read || m1_bus.write)) check_eq("m1_idle_wait", 32'(m1_bus.waitrequest), 32'd0);
      check_eq("strobe_excl", 32'(mem_bus.write && mem_bus.read), 32'd0);
    end
  end

  // ---------------- main sequence ----------------
  int          lat0, lat1, exp_lat0, exp_lat1;
  logic [31:0] rd0, rd1, exp_frz;

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_owner", 32'(dbg_owner), 32'd0);
    check_eq("rst_last_grant", 32'(dbg_last_grant), 32'd1);
    check_eq("rst_m0_rdata", m0_bus.readdata, 32'h0);
    check_eq("rst_m1_rdata", m1_bus.readdata, 32'h0);
    check_eq("rst_mem_write", 32'(mem_bus.write), 32'd0);
    check_eq("rst_mem_read", 32'(mem_bus.read), 32'd0);
    check_eq("rst_mem_addr", mem_bus.address, 32'h0);
    check_eq("rst_mem_wdata", mem_bus.writedata, 32'h0);
    check_eq("rst_m0_wait", 32'(m0_bus.waitrequest), 32'd0);

    // Loader write, CPU read back
    xfer(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat1, rd1);
    check_eq("ldr_wr_latency", 32'(lat1), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    xfer(0, 1'b0, 1'b1, 32'h10, 32'h0, lat0, rd0);
    check_eq("cpu_rd_latency", 32'(lat0), 32'd2);
    check_eq("cpu_rd_deadbeef", rd0, exp_q.pop_front());

    // Preload two words for the contention rounds
    xfer(0, 1'b1, 1'b0, 32'h20, 32'hA5A50020, lat0, rd0);
    xfer(1, 1'b1, 1'b0, 32'h24, 32'h5A5A0024, lat1, rd1);

    // Round 1: simultaneous reads (last grant = loader, so CPU wins either way)
    fork
      xfer(0, 1'b0, 1'b1, 32'h24, 32'h0, lat0, rd0);
      xfer(1, 1'b0, 1'b1, 32'h20, 32'h0, lat1, rd1);
    join
    check_eq("c1_m0_latency", 32'(lat0), 32'd2);
    check_eq("c1_m1_latency", 32'(lat1), 32'd5);

    // Round 2: loader arrives one cycle ahead and is served first
    fork
      xfer(1, 1'b0, 1'b1, 32'h10, 32'h0, lat1, rd1);
      begin
        @(posedge clk);
        xfer(0, 1'b0, 1'b1, 32'h20, 32'h0, lat0, rd0);
      end
    join
    check_eq("c2_m1_latency", 32'(lat1), 32'd2);
    check_eq("c2_m0_latency", 32'(lat0), 32'd4);

    // Round 3: simultaneous again, CPU was granted last
`ifdef MEM_ARB_RR_EN
    exp_lat0 = 5; exp_lat1 = 2;
`else
    exp_lat0 = 2; exp_lat1 = 5;
`endif
    fork
      xfer(0, 1'b0, 1'b1, 32'h24, 32'h0, lat0, rd0);
      xfer(1, 1'b0, 1'b1, 32'h24, 32'h0, lat1, rd1);
    join
    check_eq("c3_m0_latency", 32'(lat0), 32'(exp_lat0));
    check_eq("c3_m1_latency", 32'(lat1), 32'(exp_lat1));

    // Freeze for 3 cycles during the ACCESS of a CPU read
    exp_frz = ref_mem[9];
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b1, 32'h24, 32'h0);
    @(negedge clk);
    check_eq("frz_idle_wait", 32'(m0_bus.waitrequest), 32'd1);
    @(posedge clk); #1;
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("frz_mem_read", 32'(mem_bus.read), 32'd0);
      check_eq("frz_wait", 32'(m0_bus.waitrequest), 32'd1);
      check_eq("frz_state", 32'(dbg_state), 32'(ACCESS));
      @(posedge clk); #1;
    end
    clk_enable = 1'b1;
    @(negedge clk);
    check_eq("frz_resume_read", 32'(mem_bus.read), 32'd1);
    check_eq("frz_resume_addr", mem_bus.address, 32'h24);
    check_eq("frz_resume_wait", 32'(m0_bus.waitrequest), 32'd1);
    @(negedge clk);
    check_eq("frz_done_wait", 32'(m0_bus.waitrequest), 32'd0);
    check_eq("frz_done_data", m0_bus.readdata, exp_frz);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    last_rd[0] = exp_frz;
    @(negedge clk);
    check_eq("frz_data_held", m0_bus.readdata, exp_frz);

    // CPU drops its read during ACCESS: aborted, nothing captured
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b1, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("abort_mem_read", 32'(mem_bus.read), 32'd0);
    @(negedge clk);
    check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
    check_eq("abort_rdata", m0_bus.readdata, last_rd[0]);

    // Read and write together behave as a write
    xfer(0, 1'b1, 1'b1, 32'h14, 32'h12345678, lat0, rd0);
    check_eq("both_latency", 32'(lat0), 32'd1);
    check_eq("both_mem_word", mem_arr[5], 32'h12345678);
    xfer(1, 1'b0, 1'b1, 32'h14, 32'h0, lat1, rd1);

    // Reset pulsed during a loader ACCESS
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b1, 32'h14, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_mem_read", 32'(mem_bus.read), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_clear();
    @(negedge clk);
    check_eq("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_mid_mem_write", 32'(mem_bus.write), 32'd0);
    check_eq("rst_mid_mem_read2", 32'(mem_bus.read), 32'd0);
    check_eq("rst_mid_m0_rdata", m0_bus.readdata, 32'h0);
    check_eq("rst_mid_m1_rdata", m1_bus.readdata, 32'h0);
    check_eq("rst_mid_last_grant", 32'(dbg_last_grant), 32'd1);

    // Randomized traffic from both masters with random freezes
    rand_active = 1'b1;
    fork
      begin
        fork
          rand_master(0, 40);
          rand_master(1, 40);
        join
        rand_active = 1'b0;
      end
      begin
        while (rand_active) begin
          @(posedge clk); #1;
          clk_enable = ($urandom_range(0, 7) != 0);
        end
        clk_enable = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
